// File: rtl/duty_cycle_setter.sv
// Debounced up/down push-button duty setter with saturating, registered output.
// Define DUTY_SETTER_AUTOREPEAT_EN to enable hold-to-repeat (DELAY/REPEAT states).
module duty_cycle_setter #(
   parameter int WIDTH           = 10,
   parameter int MAX_VALUE       = 1000,
   parameter int MIN_VALUE       = 0,
   parameter int RESET_VALUE     = 0,
   parameter int STEP            = 1,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_up,
   input  logic             btn_down,
   output logic [WIDTH-1:0] duty,
   output logic             duty_changed,
   output logic             at_max,
   output logic             at_min
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(MAX_VALUE);
   localparam logic [WIDTH:0] MIN_X  = (WIDTH+1)'(MIN_VALUE);
   localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
   localparam logic [1:0] CMD_NONE = 2'b00;
   localparam logic [1:0] S_IDLE   = 2'd0;
`ifdef DUTY_SETTER_AUTOREPEAT_EN
   localparam logic [1:0] S_DELAY  = 2'd1;
   localparam logic [1:0] S_REPEAT = 2'd2;
   localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RC_W   = $clog2(RC_MAX + 1);
   localparam logic [RC_W-1:0] RC_DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
   localparam logic [RC_W-1:0] RC_PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);
`else
   localparam logic [1:0] S_HELD   = 2'd3;
`endif

   generate
      if (MAX_VALUE >= 2**WIDTH || MIN_VALUE > MAX_VALUE || RESET_VALUE < MIN_VALUE ||
          RESET_VALUE > MAX_VALUE || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 ||
          REPEAT_PERIOD < 1) begin : g_bad_params
         $error("duty_cycle_setter: inconsistent parameters");
      end
   endgenerate

   // Bit 0 is the up button, bit 1 the down button throughout.
   logic [1:0]            r_sync1, r_sync2, r_deb;
   logic [1:0][DB_W-1:0]  r_dbc;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         r_dbc   <= '0;
      end else begin
         r_sync1 <= {btn_down, btn_up};
         r_sync2 <= r_sync1;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_dbc[i] <= '0;
            end else if (r_dbc[i] == DB_LAST) begin
               r_deb[i] <= r_sync2[i];
               r_dbc[i] <= '0;
            end else begin
               r_dbc[i] <= r_dbc[i] + 1'b1;
            end
         end
      end
   end

   // Debounced levels double as the command code; both pressed collapses to NONE.
   logic [1:0] w_cmd;
   assign w_cmd = (r_deb == 2'b11) ? CMD_NONE : r_deb;

   logic [1:0] r_state, w_state_nx;
   logic [1:0] r_dir, w_dir_nx;
   logic       w_step;
`ifdef DUTY_SETTER_AUTOREPEAT_EN
   logic [RC_W-1:0] r_rcnt, w_rcnt_nx;
`endif

   always_comb begin
      w_step     = 1'b0;
      w_state_nx = r_state;
      w_dir_nx   = r_dir;
`ifdef DUTY_SETTER_AUTOREPEAT_EN
      w_rcnt_nx  = r_rcnt;
`endif
      if (w_cmd == CMD_NONE) begin
         w_state_nx = S_IDLE;
`ifdef DUTY_SETTER_AUTOREPEAT_EN
         w_rcnt_nx  = '0;
`endif
      end else if (r_state == S_IDLE || w_cmd != r_dir) begin
         w_step   = 1'b1;
         w_dir_nx = w_cmd;
`ifdef DUTY_SETTER_AUTOREPEAT_EN
         w_state_nx = S_DELAY;
         w_rcnt_nx  = '0;
`else
         w_state_nx = S_HELD;
`endif
      end
`ifdef DUTY_SETTER_AUTOREPEAT_EN
      else if (r_state == S_DELAY) begin
         if (r_rcnt == RC_DELAY_LAST) begin
            w_step     = 1'b1;
            w_state_nx = S_REPEAT;
            w_rcnt_nx  = '0;
         end else begin
            w_rcnt_nx  = r_rcnt + 1'b1;
         end
      end else if (r_state == S_REPEAT) begin
         if (r_rcnt == RC_PERIOD_LAST) begin
            w_step    = 1'b1;
            w_rcnt_nx = '0;
         end else begin
            w_rcnt_nx = r_rcnt + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_dir   <= CMD_NONE;
`ifdef DUTY_SETTER_AUTOREPEAT_EN
         r_rcnt  <= '0;
`endif
      end else begin
         r_state <= w_state_nx;
         r_dir   <= w_dir_nx;
`ifdef DUTY_SETTER_AUTOREPEAT_EN
         r_rcnt  <= w_rcnt_nx;
`endif
      end
   end

   // One extra bit keeps duty+STEP from wrapping; the lower clamp is checked before subtracting.
   logic [WIDTH:0]   w_ext, w_up, w_sel;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] r_duty;
   logic             r_chg, r_max, r_min;

   assign w_ext = {1'b0, r_duty};
   assign w_up  = w_ext + STEP_X;
   always_comb begin
      w_sel = w_ext;
      if (w_step) begin
         if (w_cmd == 2'b01) w_sel = (w_up > MAX_X) ? MAX_X : w_up;
         else                w_sel = (w_ext < MIN_X + STEP_X) ? MIN_X : (w_ext - STEP_X);
      end
   end
   assign w_next = WIDTH'(w_sel);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_duty <= WIDTH'(RESET_VALUE);
         r_chg  <= 1'b0;
         r_max  <= (RESET_VALUE == MAX_VALUE);
         r_min  <= (RESET_VALUE == MIN_VALUE);
      end else begin
         r_duty <= w_next;
         r_chg  <= w_step && (w_next != r_duty);
         r_max  <= (w_next == WIDTH'(MAX_VALUE));
         r_min  <= (w_next == WIDTH'(MIN_VALUE));
      end
   end

   assign duty         = r_duty;
   assign duty_changed = r_chg;
   assign at_max       = r_max;
   assign at_min       = r_min;
endmodule

// File: tb/tb_duty_cycle_setter.sv
// Scoreboard bench for duty_cycle_setter: expected (edge, duty) pairs are queued by
// the stimulus and matched against every duty_changed pulse by per-instance monitors.
module tb_duty_cycle_setter;
   localparam int W = 10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic up_a = 1'b0, dn_a = 1'b0, up_b = 1'b0, dn_b = 1'b0;
   logic [W-1:0] duty_a, duty_b;
   logic chg_a, chg_b, max_a, max_b, min_a, min_b;

   duty_cycle_setter #(.WIDTH(W), .MAX_VALUE(1000), .MIN_VALUE(0), .RESET_VALUE(0), .STEP(1),
      .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) u_a (
      .clk(clk), .rst(rst), .btn_up(up_a), .btn_down(dn_a), .duty(duty_a),
      .duty_changed(chg_a), .at_max(max_a), .at_min(min_a));

   duty_cycle_setter #(.WIDTH(W), .MAX_VALUE(1000), .MIN_VALUE(0), .RESET_VALUE(999), .STEP(1),
      .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) u_b (
      .clk(clk), .rst(rst), .btn_up(up_b), .btn_down(dn_b), .duty(duty_b),
      .duty_changed(chg_b), .at_max(max_b), .at_min(min_b));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct { int cyc; int duty; } exp_t;
   exp_t q_a[$];
   exp_t q_b[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_a(input int c, input int d);
      exp_t e;
      e.cyc = c; e.duty = d;
      q_a.push_back(e);
   endtask

   task automatic push_b(input int c, input int d);
      exp_t e;
      e.cyc = c; e.duty = d;
      q_b.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitors: every pulse must match the head of the queue; a head left behind is a missed step.
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (q_a.size() > 0 && q_a[0].cyc < cyc) begin
         e = q_a.pop_front();
         checks++; errors++;
         $display("FAIL a_missing_step: no pulse at edge %0d for duty %0d", e.cyc, e.duty);
      end
      if (chg_a !== 1'b0) begin
         if (q_a.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected_pulse: duty %0d at edge %0d, none expected", duty_a, cyc);
         end else begin
            e = q_a.pop_front();
            chk("a_step_edge", cyc, e.cyc);
            chk("a_duty", duty_a, e.duty);
            chk("a_at_max", max_a, e.duty == 1000);
            chk("a_at_min", min_a, e.duty == 0);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (q_b.size() > 0 && q_b[0].cyc < cyc) begin
         e = q_b.pop_front();
         checks++; errors++;
         $display("FAIL b_missing_step: no pulse at edge %0d for duty %0d", e.cyc, e.duty);
      end
      if (chg_b !== 1'b0) begin
         if (q_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_pulse: duty %0d at edge %0d, none expected", duty_b, cyc);
         end else begin
            e = q_b.pop_front();
            chk("b_step_edge", cyc, e.cyc);
            chk("b_duty", duty_b, e.duty);
            chk("b_at_max", max_b, e.duty == 1000);
            chk("b_at_min", min_b, e.duty == 0);
         end
      end
   end

   initial begin
      int base;
      // Reset with the up button already held: no step until it re-passes debounce.
      up_a = 1'b1;
      tick(3);
      chk("rst_duty_a", duty_a, 0);
      chk("rst_at_min_a", min_a, 1);
      chk("rst_at_max_a", max_a, 0);
      chk("rst_chg_a", chg_a, 0);
      chk("rst_duty_b", duty_b, 999);
      chk("rst_at_max_b", max_b, 0);
      rst = 1'b1;
      base = cyc;
      push_a(base + 7, 1);
      tick(5);
      up_a = 1'b0;
      tick(15);

      // Single clean press.
      base = cyc;
      up_a = 1'b1;
      push_a(base + 7, 2);
      tick(5);
      up_a = 1'b0;
      tick(15);

      // Bounce shorter than the debounce window is ignored.
      for (int i = 0; i < 5; i++) begin
         up_a = 1'b1; tick(2);
         up_a = 1'b0; tick(2);
      end
      tick(10);
      chk("bounce_duty", duty_a, 2);

      // Long hold.
      base = cyc;
      up_a = 1'b1;
      push_a(base + 7, 3);
`ifdef DUTY_SETTER_AUTOREPEAT_EN
      for (int k = 0; k < 10; k++) push_a(base + 17 + 3*k, 4 + k);
`endif
      tick(40);
      up_a = 1'b0;
      tick(15);
`ifdef DUTY_SETTER_AUTOREPEAT_EN
      chk("hold_duty", duty_a, 13);
`else
      chk("hold_duty", duty_a, 3);
`endif

      // Reset again, then press down at the lower limit: no change, no pulse.
      rst = 1'b0;
      tick(2);
      rst = 1'b1;
      chk("rst2_duty_a", duty_a, 0);
      chk("rst2_at_min_a", min_a, 1);
      dn_a = 1'b1;
      tick(5);
      dn_a = 1'b0;
      tick(15);
      chk("min_sat_duty", duty_a, 0);
      chk("min_sat_at_min", min_a, 1);

      // Upper saturation on the instance reset to 999.
      base = cyc;
      up_b = 1'b1;
      push_b(base + 7, 1000);
      tick(40);
      up_b = 1'b0;
      tick(15);
      chk("max_sat_duty", duty_b, 1000);
      chk("max_sat_at_max", max_b, 1);

      // Up held, down added (both -> stop), up released (immediate down step, then repeat).
      base = cyc;
      up_a = 1'b1;
      push_a(base + 7, 1);
`ifdef DUTY_SETTER_AUTOREPEAT_EN
      push_a(base + 17, 2);
      push_a(base + 20, 3);
      push_a(base + 23, 4);
      push_a(base + 26, 5);
`endif
      tick(21);
      dn_a = 1'b1;
      tick(9);
      up_a = 1'b0;
`ifdef DUTY_SETTER_AUTOREPEAT_EN
      push_a(base + 37, 4);
      push_a(base + 47, 3);
      push_a(base + 50, 2);
      push_a(base + 53, 1);
      push_a(base + 56, 0);
`else
      push_a(base + 37, 0);
`endif
      tick(25);
      dn_a = 1'b0;
      tick(15);
      chk("simul_duty", duty_a, 0);
      chk("simul_at_min", min_a, 1);

      chk("a_pending", q_a.size(), 0);
      chk("b_pending", q_b.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
